// File: rtl/lfsr_word_harvester.sv
// Reader side of the 16-bit LFSR entropy mixer: samples the LFSR once per settle
// period, screens samples with a repetition health test, and buffers them in a FIFO.
module lfsr_word_harvester #(
  parameter int SETTLE_CLOCKS = 16,
  parameter int DEPTH         = 4,
  parameter int REPEAT_LIMIT  = 3
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        enable,
  input  logic [15:0] lfsr,
  input  logic        clear,
  output logic [15:0] data,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        overflow,
  output logic        health_fail,
  output logic [4:0]  fill
);

  localparam int         AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CLOCKS - 1);
  localparam logic [3:0] REP_LIMIT   = 4'(REPEAT_LIMIT);
  localparam logic [4:0] DEPTH_W     = 5'(DEPTH);

  logic [7:0]    r_settle_cnt;
  logic [3:0]    r_rep_cnt;
  logic [15:0]   r_last;
  logic          r_last_valid;
  logic          r_overflow;
  logic          r_health_fail;
  logic [4:0]    r_fill;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [15:0]   r_mem [DEPTH];

  logic          w_strobe;
  logic          w_match;
  logic [3:0]    w_rep_next;
  logic          w_trip;
  logic          w_push_req;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;

  // Handshake: a word transfers on a rising CLK edge where data_valid and
  // data_ready are both high; data is stable while data_valid=1 and data_ready=0.
  always_comb begin
    w_strobe   = 1'b0;
    w_match    = 1'b0;
    w_rep_next = 4'd1;
    w_trip     = 1'b0;
    w_push_req = 1'b0;
    w_full     = 1'b0;
    w_pop      = 1'b0;
    w_push     = 1'b0;
    w_drop     = 1'b0;

    w_strobe = enable && (r_settle_cnt == SETTLE_LAST);
    w_match  = r_last_valid && (lfsr == r_last);
    if (w_match) begin
      w_rep_next = (r_rep_cnt == 4'hF) ? 4'hF : r_rep_cnt + 4'd1;
    end
    w_trip = w_strobe && (w_rep_next == REP_LIMIT);

    // A strobe coinciding with clear is discarded entirely.
    w_push_req = w_strobe && !clear && !r_health_fail && !w_trip;
    w_full     = (r_fill == DEPTH_W);
    w_pop      = data_valid && data_ready && !clear;
    w_push     = w_push_req && (!w_full || w_pop);
    w_drop     = w_push_req && w_full && !w_pop;
  end

  // Settle counter is free-running across clear; only reset restarts it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_settle_cnt <= 8'd0;
    end else if (enable) begin
      r_settle_cnt <= (r_settle_cnt == SETTLE_LAST) ? 8'd0 : r_settle_cnt + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rep_cnt     <= 4'd0;
      r_last        <= 16'd0;
      r_last_valid  <= 1'b0;
      r_health_fail <= 1'b0;
    end else if (clear) begin
      r_rep_cnt     <= 4'd0;
      r_last_valid  <= 1'b0;
      r_health_fail <= 1'b0;
    end else if (w_strobe) begin
      r_rep_cnt    <= w_rep_next;
      r_last       <= lfsr;
      r_last_valid <= 1'b1;
      if (w_trip) begin
        r_health_fail <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_fill     <= 5'd0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_fill     <= 5'd0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_fill <= r_fill + 5'd1;
      end else if (w_pop && !w_push) begin
        r_fill <= r_fill - 5'd1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= lfsr;
    end
  end

  assign data_valid  = (r_fill != 5'd0);
  assign data        = data_valid ? r_mem[r_rd_ptr] : 16'd0;
  assign overflow    = r_overflow;
  assign health_fail = r_health_fail;
  assign fill        = r_fill;

endmodule

// File: doc/lfsr_word_harvester.md
Name: lfsr_word_harvester

Overview:
- Reader side of the 16-bit Fibonacci LFSR entropy mixer.
- Samples the LFSR word only after SETTLE_CLOCKS shifts have flushed the previous word.
- Runs a repetition health test on each sampled word.
- Buffers accepted words in a small FIFO and hands them to a consumer over a valid/ready handshake.

Parameters:
- SETTLE_CLOCKS, 16, enabled clocks between samples (2..255); 16 = full LFSR flush.
- DEPTH, 4, FIFO entries; power of two, 2..16.
- REPEAT_LIMIT, 3, consecutive identical samples that trip health_fail (2..15).

Ports:
- CLK  input  1  clock; all state on rising edge.
- RST_N  input  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to CLK.
- enable  input  1  harvest enable; settle counter advances only while high.
- lfsr  input  16  LFSR state; bit 0 = newest shifted bit, bit 15 = oldest.
- clear  input  1  synchronous; clears sticky flags and flushes FIFO.
- data  output  16  FIFO head word.
- data_valid  output  1  FIFO non-empty.
- data_ready  input  1  consumer accepts head when high together with data_valid.
- overflow  output  1  sticky; a sample was dropped because FIFO was full.
- health_fail  output  1  sticky; repetition limit reached.
- fill  output  5  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (RST_N low, async):
  - data=0, data_valid=0, overflow=0, health_fail=0, fill=0.
  - settle counter=0, repeat counter=0, last-sample register=0, last-sample-valid=0.
- Settle counter:
  - Increments on each CLK with enable=1.
  - Holds when enable=0; not cleared by enable low.
  - At count SETTLE_CLOCKS-1 with enable=1, it wraps to 0 and generates a sample strobe that cycle.
  - First strobe occurs on the SETTLE_CLOCKS-th enabled clock after reset; lfsr is sampled on that same edge.
- Health test, on each strobe:
  - If last-sample-valid and lfsr == last-sample, repeat counter increments (saturates at 15). Otherwise repeat counter = 1.
  - last-sample <= lfsr; last-sample-valid <= 1.
  - When the new repeat count equals REPEAT_LIMIT, health_fail <= 1 and that word is not pushed.
- Push rule:
  - Strobe pushes lfsr into FIFO iff health_fail=0 (pre-edge value) and the trip condition above is false.
  - If FIFO full and no pop this cycle: sample dropped, overflow <= 1.
  - If full and pop this cycle: push accepted; fill unchanged.
- Pop:
  - Occurs when data_valid & data_ready.
  - Head advances on that edge; data shows the next entry in the following cycle.
  - data is first-word-fall-through: a word pushed into an empty FIFO appears on data with data_valid=1 the cycle after the strobe edge (latency 1).
- Simultaneous push/pop:
  - Empty FIFO: no pop is possible (data_valid=0); push proceeds.
  - Otherwise both occur; fill unchanged.
- data holds its value while data_valid=1 and data_ready=0. data is don't-care when data_valid=0.
- fill = pushes minus pops; read/write pointers wrap modulo DEPTH.
- clear (sync, highest priority after reset):
  - Flushes FIFO (fill=0, data_valid=0).
  - overflow=0, health_fail=0, repeat counter=0, last-sample-valid=0.
  - Settle counter is not cleared.
  - A strobe in the same cycle as clear is discarded.
- health_fail blocks all further pushes until clear or reset. Words already in the FIFO remain poppable.
- Reset mid-transfer discards all buffered words; no partial state survives.

Test Plan:
- Reset, enable=1, lfsr incrementing by 1 each cycle, data_ready=1 -> first data_valid pulse the cycle after the 16th enabled edge; data = lfsr value at that edge; one word every 16 clocks.
- enable toggles 1/0 each cycle -> samples spaced 32 clocks; settle count holds across low cycles.
- data_ready=0, DEPTH=4, 6 strobes -> fill reaches 4; overflow=1 after 5th strobe; then popping 4 words returns the first 4 samples in order.
- lfsr held constant at 16'hACE1 -> first 2 strobes pushed; 3rd strobe sets health_fail=1 and is not pushed; fill stays 2; later strobes not pushed.
- health_fail=1, pulse clear -> flags 0, FIFO empty, next strobe pushes normally.
- RST_N low asynchronously mid-settle with fill=3 -> outputs zero immediately (before next CLK edge); after release, first sample after 16 enabled clocks.
